// File: rtl/seg_scan.sv
// Time-multiplexed six-digit 7-segment scanner with a frame-synchronous, double-buffered display register.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module seg_scan #(
    parameter int SCAN_DIV = 50000,
    parameter bit SEG_INV  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] data_in,
    input  logic [5:0]  dp_in,
    input  logic        load,
    output logic [5:0]  sel,
    output logic [7:0]  seg,
    output logic        frame_done
);

    localparam int              CNT_W   = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] DIV_MAX = CNT_W'(SCAN_DIV - 1);
    localparam logic [7:0]      SEG_OFF = SEG_INV ? 8'hFF : 8'h00;

    // load is a one-cycle strobe with no back-pressure: every cycle it is high
    // captures data_in/dp_in into the shadow, and the latest capture wins.

    logic [CNT_W-1:0] r_div_cnt;
    logic [2:0]       r_dig_idx;
    logic [23:0]      r_shadow;
    logic [5:0]       r_dp_sh;
    logic [23:0]      r_display;
    logic [5:0]       r_dp_disp;
    logic             r_pending;
    logic [5:0]       r_sel;
    logic [7:0]       r_seg;
    logic             r_frame_done;

    logic             w_tick;
    logic             w_wrap;
    logic             w_commit;
    logic [2:0]       w_next_idx;
    logic [23:0]      w_src_data;
    logic [5:0]       w_src_dp;
    logic [3:0]       w_nibble;
    logic             w_blank;
    logic [7:0]       w_seg_raw;
    logic [7:0]       w_seg_next;
    logic [5:0]       w_sel_next;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] code;
        case (nib)
            4'd0:    code = 7'h3F;
            4'd1:    code = 7'h06;
            4'd2:    code = 7'h5B;
            4'd3:    code = 7'h4F;
            4'd4:    code = 7'h66;
            4'd5:    code = 7'h6D;
            4'd6:    code = 7'h7D;
            4'd7:    code = 7'h07;
            4'd8:    code = 7'h7F;
            4'd9:    code = 7'h6F;
            default: code = 7'h40;
        endcase
        return code;
    endfunction

    assign w_tick     = (r_div_cnt == DIV_MAX);
    assign w_wrap     = w_tick && (r_dig_idx == 3'd5);
    assign w_commit   = w_wrap && r_pending;
    assign w_next_idx = (r_dig_idx == 3'd5) ? 3'd0 : r_dig_idx + 3'd1;

    // On the commit edge digit0 is decoded straight from the shadow so the new frame starts clean.
    assign w_src_data = w_commit ? r_shadow : r_display;
    assign w_src_dp   = w_commit ? r_dp_sh  : r_dp_disp;
    assign w_nibble   = w_src_data[{w_next_idx, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
    logic [5:0] r_blank_mask;
    logic [5:0] w_mask_src;

    // Digit i (i>0) is blanked when it and every digit above it are zero.
    function automatic logic [5:0] lz_mask(input logic [23:0] word);
        logic [5:0] mask;
        logic       lead;
        mask = 6'b000000;
        lead = 1'b1;
        for (int i = 5; i >= 1; i--) begin
            if (lead && (word[i*4 +: 4] == 4'd0)) begin
                mask[i] = 1'b1;
            end else begin
                lead = 1'b0;
            end
        end
        return mask;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_blank_mask <= 6'b111110;
        end else if (w_commit) begin
            r_blank_mask <= lz_mask(r_shadow);
        end
    end

    assign w_mask_src = w_commit ? lz_mask(r_shadow) : r_blank_mask;
    assign w_blank    = w_mask_src[w_next_idx];
`else
    assign w_blank    = 1'b0;
`endif

    assign w_seg_raw  = {w_src_dp[w_next_idx], (w_blank ? 7'h00 : seg_decode(w_nibble))};
    assign w_seg_next = SEG_INV ? ~w_seg_raw : w_seg_raw;
    assign w_sel_next = 6'b000001 << w_next_idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div_cnt    <= '0;
            r_dig_idx    <= 3'd5;
            r_shadow     <= '0;
            r_dp_sh      <= '0;
            r_display    <= '0;
            r_dp_disp    <= '0;
            r_pending    <= 1'b0;
            r_sel        <= 6'b000000;
            r_seg        <= SEG_OFF;
            r_frame_done <= 1'b0;
        end else begin
            r_div_cnt    <= w_tick ? '0 : r_div_cnt + 1'b1;
            r_frame_done <= w_wrap;

            if (load) begin
                r_shadow <= data_in;
                r_dp_sh  <= dp_in;
            end

            // A load on the commit edge keeps pending set so its value lands next frame.
            if (load) begin
                r_pending <= 1'b1;
            end else if (w_commit) begin
                r_pending <= 1'b0;
            end

            if (w_commit) begin
                r_display <= r_shadow;
                r_dp_disp <= r_dp_sh;
            end

            if (w_tick) begin
                r_dig_idx <= w_next_idx;
                r_sel     <= w_sel_next;
                r_seg     <= w_seg_next;
            end
        end
    end

    assign sel        = r_sel;
    assign seg        = r_seg;
    assign frame_done = r_frame_done;

endmodule
